wishbone_manager: RTL and testbench
===================================

# wishbone_manager

Bus-master bridge directly downstream of the CPU request unit. Accepts single-beat read/write requests on the CPU-side strobe interface (`read_i`, `write_i`, `adr_i`, `cpu_dat_i`, `sel_i`), runs one Wishbone classic cycle per request, and returns read data on `cpu_dat_o` with `busy_o` as flow control. A timeout counter aborts any cycle whose slave never acknowledges, so the pipeline cannot hang on an unmapped address.

## Interface
- `ADDR_W`, 32: address width on both sides; narrower CPU addresses are zero-extended by the instantiating level.
- `DATA_W`, 32: data width; `SEL_W` = `DATA_W/8`.
- `TIMEOUT`, 255: maximum cycles in BUSY waiting for `ACK_I`; 0 disables the timeout.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `read_i` in 1: CPU read request (level).
- `write_i` in 1: CPU write request (level).
- `adr_i` in ADDR_W: request address.
- `cpu_dat_i` in DATA_W: write data.
- `sel_i` in SEL_W: byte enables.
- `cpu_dat_o` out DATA_W: last completed read data.
- `busy_o` out 1: transaction in flight; requests are ignored while high.
- `err_o` out 1: one-cycle pulse when a cycle is aborted by the timeout.
- `CYC_O`, `STB_O`, `WE_O` out 1: Wishbone cycle, strobe, and write enable.
- `ADR_O` out ADDR_W, `DAT_O` out DATA_W, `SEL_O` out SEL_W: Wishbone address, write data, and byte select.
- `DAT_I` in DATA_W, `ACK_I` in 1: Wishbone read data and acknowledge.

## Operation
- Two states: IDLE and BUSY.
- **Reset:** when `rst` = 1 at an edge, the next cycle is IDLE with every output 0, including `cpu_dat_o`, `busy_o`, `err_o`, all Wishbone outputs, and the timeout counter. This also applies mid-transaction; the outstanding `ACK_I` is not waited for.
- **IDLE:** `busy_o` = 0, `CYC_O` = `STB_O` = 0.
  - If `write_i` or `read_i` is 1, capture `adr_i`, `cpu_dat_i` and `sel_i` into `ADR_O`, `DAT_O` and `SEL_O`, and enter BUSY.
  - `WE_O` is set to 1 if `write_i` is 1, else 0. Write has priority when both requests are high.
  - If neither request is high, stay in IDLE; `ADR_O`, `DAT_O`, `SEL_O` and `WE_O` hold their values.
- **BUSY:** `CYC_O` = `STB_O` = `busy_o` = 1. Captured outputs are stable, and CPU-side inputs are ignored.
  - **`ACK_I` = 1:** return to IDLE. For a read (`WE_O` = 0), also load `DAT_I` into `cpu_dat_o`. For a write, `cpu_dat_o` is unchanged. Clear the timeout counter.
  - **`ACK_I` = 0:** increment the timeout counter, sized $clog2(TIMEOUT+1) bits with no wrap. If `TIMEOUT` ≠ 0 and the counter equals `TIMEOUT`-1, return to IDLE, pulse `err_o` for the next cycle, and clear the counter. `cpu_dat_o` is unchanged.
- `ACK_I` asserted in IDLE is ignored.
- `cpu_dat_o` holds its value until the next successful read completes.
- `err_o` is 0 in every cycle other than the abort pulse.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- **Request acceptance:** a request sampled at edge N gives `CYC_O`/`STB_O`/`busy_o` = 1 from cycle N+1.
- **Minimum transaction:** `ACK_I` high during the first BUSY cycle (sampled at edge N+1) gives `busy_o` = 0 and valid `cpu_dat_o` in cycle N+2. The total is 2 cycles from request to data.
- **Back-to-back:** a request still held high in the cycle where `busy_o` returns to 0 is accepted at that edge. BUSY is re-entered at N+3, with one IDLE cycle between consecutive Wishbone cycles (`CYC_O` deasserts for 1 cycle).
- **Timeout:** with no `ACK_I`, BUSY lasts exactly `TIMEOUT` cycles. `err_o` = 1 and `busy_o` = 0 in the following cycle.
- **Late `ACK_I`:** an acknowledge arriving in the same cycle the counter reaches the limit counts as a normal completion, not an error.

## Test plan
- **Reset values:** drive `rst` = 1 for 2 cycles during BUSY, then release -> all outputs 0, `CYC_O` drops on the cycle after the first reset edge, `ACK_I` afterwards is ignored.
- **Zero-wait-state read:** `read_i` = 1, `adr_i` = 0x0000_0010, slave acks in the first BUSY cycle with `DAT_I` = 0xDEAD_BEEF -> `ADR_O` = 0x10, `WE_O` = 0, `cpu_dat_o` = 0xDEAD_BEEF 2 cycles after the request, `busy_o` high for exactly 1 cycle.
- **Wait-stated write:** `write_i` = 1, `adr_i` = 0x14, `cpu_dat_i` = 0x1234_5678, `sel_i` = 0xF, slave waits 3 cycles -> `WE_O` = 1, `DAT_O` = 0x1234_5678, `busy_o` high 4 cycles, `cpu_dat_o` keeps its previous read value.
- **Simultaneous requests:** `read_i` = `write_i` = 1 -> `WE_O` = 1. Changing `adr_i` to 0x20 while BUSY leaves `ADR_O` at the captured value.
- **Timeout abort:** `TIMEOUT` = 4, read with the slave never acking -> BUSY for 4 cycles, then `err_o` one-cycle pulse, `busy_o` = 0, `cpu_dat_o` unchanged. A held `read_i` then starts a new cycle.
- **Back-to-back fetches:** `read_i` held high, slave acks immediately with 0x1, then 0x2 -> `cpu_dat_o` is 0x1 then 0x2, `CYC_O` pattern 1,0,1. Spurious `ACK_I` in IDLE has no effect.

Source files
------------

// File: rtl/wishbone_manager.sv
// ============================================================================
// Module      : wishbone_manager
// Description : CPU strobe-request to Wishbone classic single-beat master,
//               with an acknowledge timeout that aborts unanswered cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_manager #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] cpu_dat_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [DATA_W-1:0] cpu_dat_o,
    output logic              busy_o,
    output logic              err_o,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    output logic [ADDR_W-1:0] ADR_O,
    output logic [DATA_W-1:0] DAT_O,
    output logic [SEL_W-1:0]  SEL_O,
    input  logic [DATA_W-1:0] DAT_I,
    input  logic              ACK_I
);

    // A one-bit counter is kept even when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] c_MAX   = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  adr_q,   adr_d;
    logic [DATA_W-1:0]  dat_q,   dat_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic               we_q,    we_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (write_i || read_i) begin
                    state_d = S_BUSY;
                    adr_d   = adr_i;
                    dat_d   = cpu_dat_i;
                    sel_d   = sel_i;
                    we_d    = write_i;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                // An acknowledge wins over a timeout landing in the same cycle.
                if (ACK_I) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!we_q) begin
                        rdata_d = DAT_I;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == c_LIMIT)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != c_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o    = (state_q == S_BUSY);
    assign CYC_O     = busy_o;
    assign STB_O     = busy_o;
    assign WE_O      = we_q;
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign SEL_O     = sel_q;
    assign cpu_dat_o = rdata_q;
    assign err_o     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_manager.sv
// ============================================================================
// Module      : tb_wishbone_manager
// Description : Scoreboard bench for wishbone_manager with a scripted slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wishbone_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [31:0] adr_i = '0;
    logic [31:0] cpu_dat_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] cpu_dat_o;
    logic        busy_o, err_o, CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    logic        s_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] s_dat = '1;

    assign ACK_I = s_ack | spur_ack;
    assign DAT_I = s_dat;

    wishbone_manager #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
        .adr_i(adr_i), .cpu_dat_i(cpu_dat_i), .sel_i(sel_i),
        .cpu_dat_o(cpu_dat_o), .busy_o(busy_o), .err_o(err_o),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic        err;
        int          cycles;  // -1: not checked
        int          gap;     // -1: not checked
    } exp_t;

    typedef struct {
        int          waits;   // cycles before ack; large = never
        logic [31:0] data;
    } slv_t;

    exp_t exp_q[$];
    slv_t slv_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [31:0] rdata, input logic err,
                                input int cycles, input int gap);
        exp_t e;
        e.adr = adr; e.we = we; e.dat = dat; e.sel = sel;
        e.rdata = rdata; e.err = err; e.cycles = cycles; e.gap = gap;
        return e;
    endfunction

    function automatic slv_t ms(input int waits, input logic [31:0] data);
        slv_t s;
        s.waits = waits; s.data = data;
        return s;
    endfunction

    // Slave: acks after the scripted number of wait cycles; each Wishbone
    // cycle ending (ack, abort or reset) retires one script entry.
    int   scnt = 0;
    logic sacked = 1'b0;
    logic sprev = 1'b0;
    always @(negedge clk) begin
        if (sprev && !CYC_O && slv_q.size() > 0) begin
            void'(slv_q.pop_front());
            scnt = 0;
            sacked = 1'b0;
        end
        sprev = CYC_O;
        s_ack = 1'b0;
        s_dat = '1;
        if (CYC_O && slv_q.size() > 0 && !sacked) begin
            if (scnt == slv_q[0].waits) begin
                s_ack = 1'b1;
                s_dat = slv_q[0].data;
                sacked = 1'b1;
            end else begin
                scnt++;
            end
        end
    end

    // Monitor: checks captured bus fields when busy rises, completion results when it falls.
    logic m_prev = 1'b0;
    int   m_cyc = 0;
    int   m_idle = 0;
    always @(negedge clk) begin
        logic rise, fall;
        rise = busy_o && !m_prev;
        fall = !busy_o && m_prev;
        if (rise) begin
            if (exp_q.size() == 0) begin
                check("unexpected_start", {31'b0, busy_o}, 32'd0);
            end else begin
                check("adr_o", ADR_O, exp_q[0].adr);
                check("we_o", {31'b0, WE_O}, {31'b0, exp_q[0].we});
                check("dat_o", DAT_O, exp_q[0].dat);
                check("sel_o", {28'b0, SEL_O}, {28'b0, exp_q[0].sel});
                check("cyc_stb", {30'b0, CYC_O, STB_O}, 32'd3);
                if (exp_q[0].gap >= 0) check("idle_gap", m_idle, exp_q[0].gap);
            end
            m_cyc = 0;
        end
        if (busy_o) begin
            m_cyc++;
            if (exp_q.size() > 0) check("adr_stable", ADR_O, exp_q[0].adr);
        end
        if (fall) begin
            if (exp_q.size() > 0) begin
                check("cpu_dat_o", cpu_dat_o, exp_q[0].rdata);
                check("err_o", {31'b0, err_o}, {31'b0, exp_q[0].err});
                if (exp_q[0].cycles >= 0) check("busy_cycles", m_cyc, exp_q[0].cycles);
                void'(exp_q.pop_front());
            end
            m_idle = 1;
        end else if (!busy_o) begin
            m_idle++;
        end
        if (err_o === 1'b1 && !fall) check("err_spurious", {31'b0, err_o}, 32'd0);
        m_prev = busy_o;
    end

    // Hold a request until busy has risen n times, then scramble the inputs and wait for idle.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input int n);
        int   rises = 0;
        int   guard = 0;
        logic prev;
        read_i = rd; write_i = wr; adr_i = adr; cpu_dat_i = dat; sel_i = sel;
        prev = busy_o;
        while (rises < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (busy_o && !prev) rises++;
            prev = busy_o;
        end
        read_i = 1'b0; write_i = 1'b0; adr_i = 32'h20; cpu_dat_i = 32'h0BAD_0BAD; sel_i = '0;
        guard = 0;
        while (busy_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (rises < n || busy_o) check("req_timeout", {31'b0, busy_o}, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_dat_o"}, cpu_dat_o, 32'd0);
        check({tag, "_flags"}, {26'b0, busy_o, err_o, CYC_O, STB_O, WE_O, 1'b0}, 32'd0);
        check({tag, "_adr_o"}, ADR_O, 32'd0);
        check({tag, "_dat_o"}, DAT_O, 32'd0);
        check({tag, "_sel_o"}, {28'b0, SEL_O}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");
        @(negedge clk);

        // Zero-wait read
        slv_q.push_back(ms(0, 32'hDEAD_BEEF));
        exp_q.push_back(mk(32'h10, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1, -1));
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1);

        // Write with 3 wait states; ack lands on the timeout limit cycle
        slv_q.push_back(ms(3, 32'h5555_5555));
        exp_q.push_back(mk(32'h14, 1'b1, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 1'b0, 4, -1));
        do_req(1'b0, 1'b1, 32'h14, 32'h1234_5678, 4'hF, 1);

        // Simultaneous read+write: write wins; adr_i changes during BUSY
        slv_q.push_back(ms(2, 32'h6666_6666));
        exp_q.push_back(mk(32'h18, 1'b1, 32'hAABB_CCDD, 4'h3, 32'hDEAD_BEEF, 1'b0, 3, -1));
        do_req(1'b1, 1'b1, 32'h18, 32'hAABB_CCDD, 4'h3, 2'd1);

        // Timeout abort, then the held read starts a fresh cycle
        slv_q.push_back(ms(99, 32'h0));
        slv_q.push_back(ms(0, 32'hCAFE_F00D));
        exp_q.push_back(mk(32'h30, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 4, -1));
        exp_q.push_back(mk(32'h30, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1, 1));
        do_req(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 2);

        // Back-to-back fetches
        slv_q.push_back(ms(0, 32'h1));
        slv_q.push_back(ms(0, 32'h2));
        exp_q.push_back(mk(32'h50, 1'b0, 32'h0, 4'hF, 32'h1, 1'b0, 1, -1));
        exp_q.push_back(mk(32'h50, 1'b0, 32'h0, 4'hF, 32'h2, 1'b0, 1, 1));
        do_req(1'b1, 1'b0, 32'h50, 32'h0, 4'hF, 2);

        // Spurious ack in IDLE
        spur_ack = 1'b1;
        repeat (2) @(negedge clk);
        spur_ack = 1'b0;
        check("spur_busy", {31'b0, busy_o}, 32'd0);
        check("spur_cpu_dat_o", cpu_dat_o, 32'h2);

        // Reset in the middle of an unanswered read
        slv_q.push_back(ms(99, 32'h0));
        exp_q.push_back(mk(32'h40, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, -1, -1));
        read_i = 1'b1; adr_i = 32'h40; cpu_dat_i = 32'h0; sel_i = 4'hF;
        @(negedge clk);
        read_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("cyc_after_rst", {31'b0, CYC_O}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        check_all_zero("midrst");
        @(negedge clk);
        check("post_rst_busy", {31'b0, busy_o}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
